lc3_fetch_unit: RTL and testbench
=================================

# lc3_fetch_unit

LC3 instruction fetch stage, directly upstream of the decode stage. It holds the program counter, issues single-outstanding reads to instruction memory over a request/acknowledge handshake, and presents each returned instruction to decode on `dout` with `npc_out` and a one-cycle `enable_decode` pulse. Branch redirects from execute/controller reload the PC and squash any in-flight fetch.

## Interface
- `RESET_PC`, 16'h3000, PC value loaded on reset.
- `TIMEOUT_CYCLES`, 64, watchdog limit in cycles; used only when the watchdog is compiled in.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable_fetch`  in  1  1 = issue new requests; 0 = stall, no new request; an outstanding request still completes.
- `br_taken`  in  1  redirect pulse; PC is loaded with `taddr`.
- `taddr`  in  16  redirect target.
- `imem_rd`  out  1  memory read request, high for exactly one cycle per request.
- `imem_addr`  out  16  request address; equals `pc`.
- `imem_ack`  in  1  response valid; one cycle per request.
- `imem_dout`  in  16  instruction word, valid with `imem_ack`.
- `pc`  out  16  current fetch PC.
- `dout`  out  16  instruction to decode.
- `npc_out`  out  16  address of `dout` + 1.
- `enable_decode`  out  1  one-cycle pulse: `dout`/`npc_out` are new.
- `fetch_timeout`  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN. Reset state: IDLE.
- IDLE: if `enable_fetch`, go to REQ; otherwise stay.
- REQ: `imem_rd`=1, `imem_addr`=`pc` (combinational from state/pc); go to WAIT unconditionally.
- WAIT: `imem_ack` is sampled only here and in DRAIN; an ack in REQ or IDLE is ignored. On ack: `dout`<=`imem_dout`, `npc_out`<=`pc`+1, `enable_decode`<=1 for the next cycle, `pc`<=`pc`+1; then go to REQ if `enable_fetch`, else IDLE.
- DRAIN: wait for the squashed ack, discard the data, with no `enable_decode`; then go to REQ if `enable_fetch`, else IDLE.
- `br_taken` always sets `pc`<=`taddr` and has priority over the +1 increment. Next-state effect by state:
  - IDLE: stay.
  - REQ: the request still goes out with the old address; go to DRAIN.
  - WAIT without ack: go to DRAIN.
  - WAIT with ack in the same cycle: discard the data, no pulse, go to REQ/IDLE per `enable_fetch`.
  - DRAIN: stay.
- Arithmetic: 16-bit modulo. `pc`=16'hFFFF increments to 16'h0000, and `npc_out` is then 16'h0000.
- `dout`/`npc_out` hold their values between pulses.
- Reset mid-operation: all state returns to reset values immediately. A late ack arriving after reset is ignored, since the FSM is in IDLE.

## Timing
- Reset values:
  - `pc`=`imem_addr`=`RESET_PC`
  - `npc_out`=`RESET_PC`
  - `dout`=16'h0000
  - `enable_decode`=0, `imem_rd`=0, `fetch_timeout`=0
- First request: the first cycle after reset deasserts is IDLE; REQ is in the following cycle if `enable_fetch`=1.
- Request in cycle T → earliest ack T+1 → `dout`/`enable_decode` visible in T+2. The next REQ is also in T+2, giving a peak throughput of one instruction per 2 cycles.
- Memory latency is arbitrary (≥1 cycle); at most one request is outstanding.

## Configuration
- `LC3_FETCH_WATCHDOG_EN` defined:
  - A counter runs while in WAIT/DRAIN and clears on ack.
  - When it reaches `TIMEOUT_CYCLES`, `fetch_timeout`<=1, sticky until reset.
  - The FSM keeps waiting.
- Not defined: the counter is absent and `fetch_timeout` is tied to 0.

## Structure
- `lc3_fetch_pkg`:
  - `lc3_word_t` (logic [15:0])
  - `fetch_state_e` enum
  - `LC3_DEFAULT_RESET_PC` constant
- Sub-module `lc3_fetch_watchdog` holds the counter and sticky flag; it is instantiated only under the macro.

## Test plan
- Reset release with `enable_fetch`=1, ack latency 1, memory[16'h3000]=16'h1234 → `imem_rd` 1 cycle with `imem_addr`=16'h3000; `dout`=16'h1234, `npc_out`=16'h3001, `enable_decode` 1 cycle; `pc`=16'h3001.
- Ack latency 5, three sequential fetches → exactly three `enable_decode` pulses, `npc_out` 3001/3002/3003, one request outstanding at a time.
- `br_taken` with `taddr`=16'h4000 while in WAIT, then ack with 16'hDEAD → no pulse for DEAD; next request at 16'h4000.
- `enable_fetch`=0 mid-WAIT → current instruction is delivered, then no `imem_rd` until `enable_fetch`=1.
- `pc` set to 16'hFFFF via `br_taken` → `npc_out`=16'h0000, next `imem_addr`=16'h0000.
- With `LC3_FETCH_WATCHDOG_EN`, `TIMEOUT_CYCLES`=8, no ack → `fetch_timeout`=1 after 8 WAIT cycles and stays high until `reset`; without the macro it stays 0.

Source files
------------

// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC3 instruction fetch stage.
package lc3_fetch_pkg;

    typedef logic [15:0] lc3_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam lc3_word_t LC3_DEFAULT_RESET_PC = 16'h3000;

    // Program-counter increment, wrapping modulo 2^16.
    function automatic lc3_word_t lc3_inc(input lc3_word_t a);
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/lc3_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
interface lc3_fetch_if;
    import lc3_fetch_pkg::*;

    logic      imem_rd;
    lc3_word_t imem_addr;
    logic      imem_ack;
    lc3_word_t imem_dout;

    modport master (output imem_rd, imem_addr, input imem_ack, imem_dout);
    modport slave  (input imem_rd, imem_addr, output imem_ack, imem_dout);

endinterface

// File: rtl/lc3_fetch_watchdog.sv
// Fetch watchdog: counts cycles spent waiting for a memory ack and raises a
// sticky timeout flag once TIMEOUT_CYCLES consecutive waiting cycles elapse.
module lc3_fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic ack,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (!active || ack) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            // Counter parks at the limit; the flag stays set until reset.
            timeout <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC3 fetch stage: PC, single-outstanding instruction fetch, branch squash.
// Optional watchdog compiled in with `define LC3_FETCH_WATCHDOG_EN.
module lc3_fetch_unit
    import lc3_fetch_pkg::*;
#(
    parameter lc3_word_t RESET_PC       = LC3_DEFAULT_RESET_PC,
    parameter int        TIMEOUT_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_fetch,
    input  logic       br_taken,
    input  lc3_word_t  taddr,
    lc3_fetch_if.master imem,
    output lc3_word_t  pc,
    output lc3_word_t  dout,
    output lc3_word_t  npc_out,
    output logic       enable_decode,
    output logic       fetch_timeout
);

    fetch_state_e state;

    assign imem.imem_rd   = (state == ST_REQ);
    assign imem.imem_addr = pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            dout          <= 16'h0000;
            npc_out       <= RESET_PC;
            enable_decode <= 1'b0;
        end else begin
            enable_decode <= 1'b0;
            if (br_taken) pc <= taddr;
            case (state)
                ST_IDLE: begin
                    if (enable_fetch && !br_taken) state <= ST_REQ;
                end
                ST_REQ: begin
                    state <= br_taken ? ST_DRAIN : ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem.imem_ack) begin
                        // A redirect in the ack cycle squashes the returning word.
                        if (!br_taken) begin
                            dout          <= imem.imem_dout;
                            npc_out       <= lc3_inc(pc);
                            pc            <= lc3_inc(pc);
                            enable_decode <= 1'b1;
                        end
                        state <= enable_fetch ? ST_REQ : ST_IDLE;
                    end else if (br_taken) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (imem.imem_ack) state <= enable_fetch ? ST_REQ : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LC3_FETCH_WATCHDOG_EN
    lc3_fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .active  ((state == ST_WAIT) || (state == ST_DRAIN)),
        .ack     (imem.imem_ack),
        .timeout (fetch_timeout)
    );
`else
    // TIMEOUT_CYCLES is never negative, so the flag is constant 0 here.
    assign fetch_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Self-checking bench for lc3_fetch_unit: transaction-level PC/fetch model plus
// directed scenarios (first fetch, slow memory, stall, redirect, wrap, watchdog).
module tb_lc3_fetch_unit;
    import lc3_fetch_pkg::*;

`ifdef LC3_FETCH_WATCHDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif

    logic      clock = 1'b0;
    logic      reset = 1'b1;
    logic      enable_fetch = 1'b0;
    logic      br_taken = 1'b0;
    lc3_word_t taddr = 16'h0000;
    lc3_word_t pc, dout, npc_out;
    logic      enable_decode, fetch_timeout;

    lc3_fetch_if bus();

    lc3_fetch_unit #(
        .RESET_PC      (16'h3000),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable_fetch (enable_fetch),
        .br_taken     (br_taken),
        .taddr        (taddr),
        .imem         (bus.master),
        .pc           (pc),
        .dout         (dout),
        .npc_out      (npc_out),
        .enable_decode(enable_decode),
        .fetch_timeout(fetch_timeout)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check16(input string name, input lc3_word_t act, input lc3_word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int        lat = 1;
    int        mem_cnt = 0;
    lc3_word_t mem_addr_q = 16'h0000;
    bit        mute = 1'b0;
    bit        ovr_en = 1'b0;
    lc3_word_t ovr_data = 16'h0000;

    function automatic lc3_word_t mem_word(input lc3_word_t a);
        if (a == 16'h3000) return 16'h1234;
        return a ^ 16'h5A5A;
    endfunction

    initial begin
        bus.imem_ack  = 1'b0;
        bus.imem_dout = 16'hBEEF;
        forever begin
            @(posedge clock);
            #1;
            bus.imem_ack  = 1'b0;
            bus.imem_dout = 16'hBEEF;
            if (reset) begin
                mem_cnt = 0;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0 && !mute) begin
                    bus.imem_ack  = 1'b1;
                    bus.imem_dout = ovr_en ? ovr_data : mem_word(mem_addr_q);
                    ovr_en = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    lc3_word_t m_pc = 16'h3000, m_dout = 16'h0000, m_npc = 16'h3000, m_addr = 16'h0000;
    bit        m_out = 1'b0, m_sq = 1'b0, m_pulse = 1'b0;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                m_pc = 16'h3000; m_dout = 16'h0000; m_npc = 16'h3000;
                m_out = 1'b0; m_sq = 1'b0; m_pulse = 1'b0;
                check1("imem_rd_in_reset", bus.imem_rd, 1'b0);
            end
            check16("pc", pc, m_pc);
            check16("imem_addr", bus.imem_addr, m_pc);
            check16("dout", dout, m_dout);
            check16("npc_out", npc_out, m_npc);
            check1("enable_decode", enable_decode, m_pulse);
`ifndef LC3_FETCH_WATCHDOG_EN
            check1("fetch_timeout", fetch_timeout, 1'b0);
`endif
            if (!reset) begin
                m_pulse = 1'b0;
                if (bus.imem_rd) begin
                    check1("single_outstanding", m_out, 1'b0);
                    m_out = 1'b1; m_sq = 1'b0; m_addr = bus.imem_addr;
                    mem_addr_q = bus.imem_addr;
                    mem_cnt = lat;
                end
                if (br_taken) begin
                    m_pc = taddr;
                    if (m_out) m_sq = 1'b1;
                end
                if (bus.imem_ack && m_out) begin
                    if (!m_sq) begin
                        m_pulse = 1'b1;
                        m_dout  = bus.imem_dout;
                        m_npc   = m_addr + 16'd1;
                        m_pc    = m_addr + 16'd1;
                    end
                    m_out = 1'b0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; br_taken = 1'b0; enable_fetch = 1'b0; mute = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_rd(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (bus.imem_rd) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s no imem_rd within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        int        nrd;
        bit        dropped, seen_dead, got_rd, got_ed;
        lc3_word_t first_addr, first_npc, exp_npc;
        lc3_word_t npcs[$];

        // Reset values
        repeat (2) tick();
        @(negedge clock);
        check16("rst_pc", pc, 16'h3000);
        check16("rst_addr", bus.imem_addr, 16'h3000);
        check16("rst_dout", dout, 16'h0000);
        check16("rst_npc", npc_out, 16'h3000);
        check1("rst_ed", enable_decode, 1'b0);
        check1("rst_rd", bus.imem_rd, 1'b0);
        check1("rst_timeout", fetch_timeout, 1'b0);

        // First fetch, ack latency 1
        tick();
        lat = 1; enable_fetch = 1'b1; reset = 1'b0;
        @(negedge clock); check1("t1_idle_rd", bus.imem_rd, 1'b0);
        @(negedge clock); check1("t1_rd", bus.imem_rd, 1'b1);
        check16("t1_addr", bus.imem_addr, 16'h3000);
        @(negedge clock); check1("t1_wait_rd", bus.imem_rd, 1'b0);
        check1("t1_wait_ed", enable_decode, 1'b0);
        @(negedge clock); check1("t1_ed", enable_decode, 1'b1);
        check16("t1_dout", dout, 16'h1234);
        check16("t1_npc", npc_out, 16'h3001);
        check16("t1_pc", pc, 16'h3001);
        check1("t1_next_rd", bus.imem_rd, 1'b1);
        @(negedge clock); check1("t1_ed_off", enable_decode, 1'b0);
        check16("t1_dout_hold", dout, 16'h1234);

        // Latency 5, three fetches, stall mid-WAIT after the third request
        do_reset();
        lat = 5; enable_fetch = 1'b1; reset = 1'b0;
        nrd = 0; dropped = 1'b0; npcs.delete();
        for (int i = 0; i < 45; i++) begin
            @(negedge clock);
            if (bus.imem_rd) nrd++;
            if (enable_decode) npcs.push_back(npc_out);
            if (nrd == 3 && !dropped) begin
                dropped = 1'b1;
                tick();
                enable_fetch = 1'b0;
            end
        end
        check_int("t2_requests", nrd, 3);
        check_int("t2_pulses", npcs.size(), 3);
        for (int k = 0; k < 3; k++) begin
            exp_npc = 16'h3001 + 16'(k);
            check16($sformatf("t2_npc%0d", k), (k < npcs.size()) ? npcs[k] : 16'hFFFF, exp_npc);
        end
        tick();
        enable_fetch = 1'b1;
        wait_rd("t2_resume", 10);
        check16("t2_resume_addr", bus.imem_addr, 16'h3003);

        // Redirect while in WAIT; the squashed word is DEAD
        do_reset();
        lat = 3; enable_fetch = 1'b1; reset = 1'b0;
        wait_rd("t3_first", 10);
        tick();
        br_taken = 1'b1; taddr = 16'h4000; ovr_data = 16'hDEAD; ovr_en = 1'b1;
        tick();
        br_taken = 1'b0;
        seen_dead = 1'b0; got_rd = 1'b0; got_ed = 1'b0;
        first_addr = 16'h0000; first_npc = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (enable_decode && dout == 16'hDEAD) seen_dead = 1'b1;
            if (enable_decode && !got_ed) begin got_ed = 1'b1; first_npc = npc_out; end
            if (bus.imem_rd && !got_rd) begin got_rd = 1'b1; first_addr = bus.imem_addr; end
        end
        check1("t3_no_dead_pulse", seen_dead, 1'b0);
        check16("t3_redirect_addr", first_addr, 16'h4000);
        check16("t3_first_npc", first_npc, 16'h4001);

        // Wrap: redirect to FFFF from IDLE
        tick();
        enable_fetch = 1'b0;
        repeat (12) tick();
        br_taken = 1'b1; taddr = 16'hFFFF;
        tick();
        br_taken = 1'b0; enable_fetch = 1'b1;
        wait_rd("t5_rd", 10);
        check16("t5_addr", bus.imem_addr, 16'hFFFF);
        got_ed = 1'b0;
        for (int i = 0; i < 12 && !got_ed; i++) begin
            @(negedge clock);
            if (enable_decode) got_ed = 1'b1;
        end
        check1("t5_got_pulse", got_ed, 1'b1);
        check16("t5_npc", npc_out, 16'h0000);
        check1("t5_next_rd", bus.imem_rd, 1'b1);
        check16("t5_next_addr", bus.imem_addr, 16'h0000);

        // Watchdog: no ack ever arrives
        do_reset();
        lat = 1; mute = 1'b1; enable_fetch = 1'b1; reset = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clock);
        check1("t6_timeout_c9", fetch_timeout, 1'b0);
        @(negedge clock);
        check1("t6_timeout_c10", fetch_timeout, WD_ON);
        repeat (20) @(negedge clock);
        check1("t6_sticky", fetch_timeout, WD_ON);
        tick();
        reset = 1'b1;
        @(negedge clock);
        check1("t6_cleared", fetch_timeout, 1'b0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
